// File: rtl/vedic_mul16_seq.sv
// Sequential 16x16 unsigned multiplier. It reuses one Urdhva-Tiryagbhyam 8x8 core over four
// steps and returns the 32-bit product on a valid/ready port.
module vedic_mul16_seq #(
    parameter bit REG_CORE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [15:0] a_q, b_q;
    logic [31:0] acc_q, acc_d;
    logic [31:0] out_p_q, out_p_d;

    logic        accept;
    logic        issue;
    logic [1:0]  issue_tag;
    logic [7:0]  core_a, core_b;
    logic [15:0] core_p;
    logic        acc_en;
    logic [15:0] acc_pp;
    logic [1:0]  acc_tag;
    logic [31:0] pp_ext;
    logic [31:0] acc_sum;
    logic        last;

    // 2x2 vertical-and-crosswise cell built from two half adders.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
        logic [3:0] r;
        logic       cross0;
        logic       cross1;
        logic       c;
        cross0 = a[1] & b[0];
        cross1 = a[0] & b[1];
        c      = cross0 & cross1;
        r[0]   = a[0] & b[0];
        r[1]   = cross0 ^ cross1;
        r[2]   = (a[1] & b[1]) ^ c;
        r[3]   = (a[1] & b[1]) & c;
        return r;
    endfunction

    function automatic logic [7:0] vedic_4x4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic_2x2(a[1:0], b[1:0]);
        q1 = vedic_2x2(a[3:2], b[1:0]);
        q2 = vedic_2x2(a[1:0], b[3:2]);
        q3 = vedic_2x2(a[3:2], b[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    function automatic logic [15:0] vedic_8x8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q0, q1, q2, q3;
        q0 = vedic_4x4(a[3:0], b[3:0]);
        q1 = vedic_4x4(a[7:4], b[3:0]);
        q2 = vedic_4x4(a[3:0], b[7:4]);
        q3 = vedic_4x4(a[7:4], b[7:4]);
        return {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
    endfunction

    assign in_ready  = (state_q == StIdle);
    assign busy      = ~in_ready;
    assign out_valid = (state_q == StDone);
    assign out_p     = out_p_q;

    // Abort wins over a new operand pair presented in IDLE.
    assign accept    = in_ready & in_valid & ~abort;

    assign issue     = (state_q == StCalc) && (step_q < 3'd4);
    assign issue_tag = step_q[1:0];

    always_comb begin
        core_a = a_q[7:0];
        core_b = b_q[7:0];
        unique case (issue_tag)
            2'd0: begin
                core_a = a_q[7:0];
                core_b = b_q[7:0];
            end
            2'd1: begin
                core_a = a_q[15:8];
                core_b = b_q[7:0];
            end
            2'd2: begin
                core_a = a_q[7:0];
                core_b = b_q[15:8];
            end
            2'd3: begin
                core_a = a_q[15:8];
                core_b = b_q[15:8];
            end
        endcase
    end

    assign core_p = vedic_8x8(core_a, core_b);

    generate
        if (REG_CORE) begin : g_core_reg
            // Accumulation runs one cycle behind issue; the tag follows its product.
            logic [15:0] pp_q;
            logic [1:0]  tag_q;
            logic        vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pp_q  <= '0;
                    tag_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= issue & ~abort;
                    if (issue) begin
                        pp_q  <= core_p;
                        tag_q <= issue_tag;
                    end
                end
            end

            assign acc_en  = vld_q;
            assign acc_pp  = pp_q;
            assign acc_tag = tag_q;
        end else begin : g_core_comb
            assign acc_en  = issue;
            assign acc_pp  = core_p;
            assign acc_tag = issue_tag;
        end
    endgenerate

    always_comb begin
        pp_ext = {16'b0, acc_pp};
        unique case (acc_tag)
            2'd0:       pp_ext = {16'b0, acc_pp};
            2'd1, 2'd2: pp_ext = {8'b0, acc_pp, 8'b0};
            2'd3:       pp_ext = {acc_pp, 16'b0};
        endcase
    end

    assign acc_sum = acc_q + pp_ext;
    assign last    = acc_en && (acc_tag == 2'd3);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        out_p_d = out_p_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCalc;
                    step_d  = 3'd0;
                    acc_d   = '0;
                end
            end
            StCalc: begin
                if (abort) begin
                    state_d = StIdle;
                    step_d  = 3'd0;
                    acc_d   = '0;
                end else begin
                    if (issue) begin
                        step_d = step_q + 3'd1;
                    end
                    if (acc_en) begin
                        acc_d = acc_sum;
                    end
                    if (last) begin
                        state_d = StDone;
                        step_d  = 3'd0;
                        out_p_d = acc_sum;
                    end
                end
            end
            StDone: begin
                if (abort) begin
                    state_d = StIdle;
                    acc_d   = '0;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                step_d  = 3'd0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            acc_q   <= '0;
            out_p_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            out_p_q <= out_p_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

endmodule
